// File: rtl/generic_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO: pointer arithmetic and status compare.
// Pointers are passed zero-extended to ptr_t so one function serves any channel depth.
package generic_fifo_pkg;

    localparam int CH_PTR_WIDTH_DEF = 3;
    localparam int DEPTH_PER_CH     = 1 << CH_PTR_WIDTH_DEF;
    localparam int PTR_MAX_W        = 15;

    typedef logic [PTR_MAX_W:0] ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_stat_t;

    function automatic int depth_of(input int ptr_w);
        return 1 << ptr_w;
    endfunction

    // Occupancy modulo 2^(ptr_w+1); the wrap bit makes full distinguishable from empty.
    function automatic ptr_t calc_used(input ptr_t wp, input ptr_t rp, input int ptr_w);
        ptr_t mask;
        mask = ptr_t'((32'd1 << (ptr_w + 1)) - 32'd1);
        return (wp - rp) & mask;
    endfunction

    function automatic fifo_stat_t calc_stat(input ptr_t wp, input ptr_t rp, input int ptr_w);
        fifo_stat_t s;
        ptr_t       diff;
        diff    = wp ^ rp;
        s.empty = (diff == '0);
        s.full  = (diff == (ptr_t'(1) << ptr_w));
        return s;
    endfunction

endpackage

// File: rtl/generic_mc_fifo_rf_if.sv
// Request/response and status bundle of the multi-channel FIFO.
interface generic_mc_fifo_rf_if #(
    parameter int NUM_CH       = 4,
    parameter int CH_WIDTH     = 2,
    parameter int CH_PTR_WIDTH = 3,
    parameter int DAT_WIDTH    = 20
);
    logic                                   wr_op;
    logic [CH_WIDTH-1:0]                    wr_ch;
    logic [DAT_WIDTH-1:0]                   wr_data;
    logic                                   rd_op;
    logic [CH_WIDTH-1:0]                    rd_ch;
    logic [DAT_WIDTH-1:0]                   rd_data;
    logic                                   rd_valid;
    logic [NUM_CH-1:0]                      flush;
    logic [NUM_CH-1:0]                      full;
    logic [NUM_CH-1:0]                      empty;
    logic [NUM_CH-1:0]                      afull;
    logic [NUM_CH-1:0]                      aempty;
    logic [NUM_CH*(CH_PTR_WIDTH+1)-1:0]     entry_used;
    logic                                   wr_full_err;
    logic                                   rd_empty_err;

    modport master (
        output wr_op, wr_ch, wr_data, rd_op, rd_ch, flush,
        input  rd_data, rd_valid, full, empty, afull, aempty, entry_used,
               wr_full_err, rd_empty_err
    );

    modport slave (
        input  wr_op, wr_ch, wr_data, rd_op, rd_ch, flush,
        output rd_data, rd_valid, full, empty, afull, aempty, entry_used,
               wr_full_err, rd_empty_err
    );

endinterface

// File: rtl/generic_2p_rf.sv
// Two-port register file: one synchronous write and one registered read per cycle.
// The read register clears on reset and holds its value when no read is issued.
module generic_2p_rf #(
    parameter int MEM_SIZE = 32,
    parameter int AW       = 5,
    parameter int DW       = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/generic_mc_fifo_ch_ctrl.sv
// Per-channel pointer pair with registered status derived from the next-state pointers,
// so status seen in a cycle already reflects everything accepted in the cycle before.
module generic_mc_fifo_ch_ctrl
    import generic_fifo_pkg::*;
#(
    parameter int CH_PTR_WIDTH = 3,
    parameter int AFULL_LVL    = 6,
    parameter int AEMPTY_LVL   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_acc,
    input  logic                    rd_acc,
    input  logic                    flush,
    output logic [CH_PTR_WIDTH-1:0] wr_addr,
    output logic [CH_PTR_WIDTH-1:0] rd_addr,
    output logic [CH_PTR_WIDTH:0]   used,
    output logic                    full,
    output logic                    empty,
    output logic                    afull,
    output logic                    aempty
);

    localparam logic [CH_PTR_WIDTH:0] PTR_ONE = (CH_PTR_WIDTH+1)'(1);

    logic [CH_PTR_WIDTH:0] wr_ptr, rd_ptr;
    logic [CH_PTR_WIDTH:0] wr_ptr_d, rd_ptr_d, used_d;
    fifo_stat_t            stat_d;

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        // flush wins over any same-cycle accept on this channel
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr + PTR_ONE;
        end
        used_d = (CH_PTR_WIDTH+1)'(calc_used(ptr_t'(wr_ptr_d), ptr_t'(rd_ptr_d), CH_PTR_WIDTH));
        stat_d = calc_stat(ptr_t'(wr_ptr_d), ptr_t'(rd_ptr_d), CH_PTR_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            used   <= used_d;
            full   <= stat_d.full;
            empty  <= stat_d.empty;
            afull  <= (int'(used_d) >= AFULL_LVL);
            aempty <= (int'(used_d) <= AEMPTY_LVL);
        end
    end

    assign wr_addr = wr_ptr[CH_PTR_WIDTH-1:0];
    assign rd_addr = rd_ptr[CH_PTR_WIDTH-1:0];

endmodule

// File: rtl/generic_mc_fifo_rf.sv
// Multi-channel FIFO over one shared two-port register file, one fixed partition per channel.
// Top level: request decode against registered status, error/rd_valid registers, status flattening.
module generic_mc_fifo_rf
    import generic_fifo_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_WIDTH     = 2,
    parameter int CH_PTR_WIDTH = 3,
    parameter int DAT_WIDTH    = 20,
    parameter int AFULL_LVL    = 6,
    parameter int AEMPTY_LVL   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    generic_mc_fifo_rf_if.slave  bus
);

    localparam int UW       = CH_PTR_WIDTH + 1;
    localparam int AW       = CH_WIDTH + CH_PTR_WIDTH;
    localparam int MEM_SIZE = NUM_CH * depth_of(CH_PTR_WIDTH);

    logic [NUM_CH-1:0]       wr_acc, rd_acc;
    logic [NUM_CH-1:0]       full_v, empty_v, afull_v, aempty_v;
    logic [CH_PTR_WIDTH-1:0] wr_addr_v [NUM_CH];
    logic [CH_PTR_WIDTH-1:0] rd_addr_v [NUM_CH];
    logic [UW-1:0]           used_v    [NUM_CH];
    logic [NUM_CH*UW-1:0]    used_flat;
    logic [CH_PTR_WIDTH-1:0] wr_lo, rd_lo;
    logic                    wr_legal, rd_legal;
    logic                    wr_err_d, rd_err_d;
    logic                    rf_we, rf_re;
    logic                    rd_valid_q, wr_full_err_q, rd_empty_err_q;
    logic [DAT_WIDTH-1:0]    rf_rd_data;

    assign wr_legal = ({1'b0, bus.wr_ch} < (CH_WIDTH+1)'(NUM_CH));
    assign rd_legal = ({1'b0, bus.rd_ch} < (CH_WIDTH+1)'(NUM_CH));

    // A flushed channel silently swallows requests; only full/empty/illegal raise errors.
    always_comb begin
        wr_acc   = '0;
        rd_acc   = '0;
        wr_lo    = '0;
        rd_lo    = '0;
        wr_err_d = bus.wr_op && !wr_legal;
        rd_err_d = bus.rd_op && !rd_legal;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.wr_ch == CH_WIDTH'(c)) begin
                wr_lo = wr_addr_v[c];
                if (bus.wr_op && !bus.flush[c]) begin
                    if (full_v[c]) wr_err_d  = 1'b1;
                    else           wr_acc[c] = 1'b1;
                end
            end
            if (bus.rd_ch == CH_WIDTH'(c)) begin
                rd_lo = rd_addr_v[c];
                if (bus.rd_op && !bus.flush[c]) begin
                    if (empty_v[c]) rd_err_d  = 1'b1;
                    else            rd_acc[c] = 1'b1;
                end
            end
        end
    end

    assign rf_we = |wr_acc;
    assign rf_re = |rd_acc;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        generic_mc_fifo_ch_ctrl #(
            .CH_PTR_WIDTH (CH_PTR_WIDTH),
            .AFULL_LVL    (AFULL_LVL),
            .AEMPTY_LVL   (AEMPTY_LVL)
        ) u_ctrl (
            .clk     (clk),
            .reset   (reset),
            .wr_acc  (wr_acc[c]),
            .rd_acc  (rd_acc[c]),
            .flush   (bus.flush[c]),
            .wr_addr (wr_addr_v[c]),
            .rd_addr (rd_addr_v[c]),
            .used    (used_v[c]),
            .full    (full_v[c]),
            .empty   (empty_v[c]),
            .afull   (afull_v[c]),
            .aempty  (aempty_v[c])
        );
    end

    generic_2p_rf #(
        .MEM_SIZE (MEM_SIZE),
        .AW       (AW),
        .DW       (DAT_WIDTH)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rf_we),
        .wr_addr ({bus.wr_ch, wr_lo}),
        .wr_data (bus.wr_data),
        .rd_en   (rf_re),
        .rd_addr ({bus.rd_ch, rd_lo}),
        .rd_data (rf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q     <= 1'b0;
            wr_full_err_q  <= 1'b0;
            rd_empty_err_q <= 1'b0;
        end else begin
            rd_valid_q     <= rf_re;
            wr_full_err_q  <= wr_err_d;
            rd_empty_err_q <= rd_err_d;
        end
    end

    always_comb begin
        used_flat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            used_flat[c*UW +: UW] = used_v[c];
        end
    end

    assign bus.rd_data      = rf_rd_data;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.wr_full_err  = wr_full_err_q;
    assign bus.rd_empty_err = rd_empty_err_q;
    assign bus.full         = full_v;
    assign bus.empty        = empty_v;
    assign bus.afull        = afull_v;
    assign bus.aempty       = aempty_v;
    assign bus.entry_used   = used_flat;

endmodule

// File: tb/tb_generic_mc_fifo_rf.sv
// Bench for generic_mc_fifo_rf: directed scenarios plus random traffic against a queue model,
// and a three-channel instance for illegal-channel and reset-with-read cases.
module tb_generic_mc_fifo_rf;

    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int PW    = 3;
    localparam int DW    = 20;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 1;
    localparam int UW    = PW + 1;

    logic clk = 1'b0;
    logic rst4, rst3;
    always #5 clk = ~clk;

    generic_mc_fifo_rf_if #(.NUM_CH(NCH), .CH_WIDTH(CW), .CH_PTR_WIDTH(PW), .DAT_WIDTH(DW)) bus4 ();
    generic_mc_fifo_rf_if #(.NUM_CH(3),   .CH_WIDTH(CW), .CH_PTR_WIDTH(PW), .DAT_WIDTH(DW)) bus3 ();

    generic_mc_fifo_rf #(
        .NUM_CH(NCH), .CH_WIDTH(CW), .CH_PTR_WIDTH(PW), .DAT_WIDTH(DW),
        .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4.slave)
    );

    generic_mc_fifo_rf #(
        .NUM_CH(3), .CH_WIDTH(CW), .CH_PTR_WIDTH(PW), .DAT_WIDTH(DW),
        .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // reference model: one queue per channel plus the expected registered outputs
    logic [DW-1:0] mq [NCH][$];
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid, m_wr_err, m_rd_err;

    task automatic check_all();
        logic [NCH-1:0]    ef, ee, eaf, eae;
        logic [NCH*UW-1:0] eu;
        int                n;
        for (int c = 0; c < NCH; c++) begin
            n              = mq[c].size();
            ef[c]          = (n == DEPTH);
            ee[c]          = (n == 0);
            eaf[c]         = (n >= AFL);
            eae[c]         = (n <= AEL);
            eu[c*UW +: UW] = UW'(n);
        end
        chk("full",         64'(bus4.full),         64'(ef));
        chk("empty",        64'(bus4.empty),        64'(ee));
        chk("afull",        64'(bus4.afull),        64'(eaf));
        chk("aempty",       64'(bus4.aempty),       64'(eae));
        chk("entry_used",   64'(bus4.entry_used),   64'(eu));
        chk("rd_valid",     64'(bus4.rd_valid),     64'(m_rd_valid));
        chk("rd_data",      64'(bus4.rd_data),      64'(m_rd_data));
        chk("wr_full_err",  64'(bus4.wr_full_err),  64'(m_wr_err));
        chk("rd_empty_err", 64'(bus4.rd_empty_err), 64'(m_rd_err));
    endtask

    task automatic step(input bit rst, input bit wop, input int wch, input logic [DW-1:0] wd,
                        input bit rop, input int rch, input logic [NCH-1:0] fl);
        bit wacc, racc;
        rst4          = rst;
        bus4.wr_op    = wop;
        bus4.wr_ch    = CW'(wch);
        bus4.wr_data  = wd;
        bus4.rd_op    = rop;
        bus4.rd_ch    = CW'(rch);
        bus4.flush    = fl;
        if (rst) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            m_wr_err   = 1'b0;
            m_rd_err   = 1'b0;
        end else begin
            wacc       = wop && !fl[wch] && (mq[wch].size() < DEPTH);
            m_wr_err   = wop && !fl[wch] && (mq[wch].size() == DEPTH);
            racc       = rop && !fl[rch] && (mq[rch].size() > 0);
            m_rd_err   = rop && !fl[rch] && (mq[rch].size() == 0);
            m_rd_valid = racc;
            if (racc) m_rd_data = mq[rch].pop_front();
            if (wacc) mq[wch].push_back(wd);
            for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic drive3(input bit rst, input bit wop, input int wch, input logic [DW-1:0] wd,
                          input bit rop, input int rch);
        rst3         = rst;
        bus3.wr_op   = wop;
        bus3.wr_ch   = CW'(wch);
        bus3.wr_data = wd;
        bus3.rd_op   = rop;
        bus3.rd_ch   = CW'(rch);
        bus3.flush   = '0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int wp, rp;
        rst4 = 1'b1;
        bus4.wr_op = 1'b0; bus4.wr_ch = '0; bus4.wr_data = '0;
        bus4.rd_op = 1'b0; bus4.rd_ch = '0; bus4.flush   = '0;

        // three-channel instance: channel 3 is illegal
        drive3(1'b1, 1'b0, 0, '0, 1'b0, 0);
        drive3(1'b1, 1'b0, 0, '0, 1'b0, 0);
        chk("n3_reset_empty", 64'(bus3.empty),      64'h7);
        chk("n3_reset_aempty",64'(bus3.aempty),     64'h7);
        drive3(1'b0, 1'b1, 3, 20'h12345, 1'b1, 3);
        chk("n3_ill_wr_err",  64'(bus3.wr_full_err),  64'h1);
        chk("n3_ill_rd_err",  64'(bus3.rd_empty_err), 64'h1);
        chk("n3_ill_rd_valid",64'(bus3.rd_valid),     64'h0);
        chk("n3_ill_used",    64'(bus3.entry_used),   64'h0);
        chk("n3_ill_empty",   64'(bus3.empty),        64'h7);
        drive3(1'b0, 1'b0, 0, '0, 1'b0, 0);
        chk("n3_err_pulse_w", 64'(bus3.wr_full_err),  64'h0);
        chk("n3_err_pulse_r", 64'(bus3.rd_empty_err), 64'h0);
        drive3(1'b0, 1'b1, 2, 20'hABCDE, 1'b0, 0);
        chk("n3_wr_used",     64'(bus3.entry_used),   64'h100);
        drive3(1'b1, 1'b0, 0, '0, 1'b1, 2);
        chk("n3_rst_rd_valid",64'(bus3.rd_valid),     64'h0);
        chk("n3_rst_rd_data", 64'(bus3.rd_data),      64'h0);
        chk("n3_rst_used",    64'(bus3.entry_used),   64'h0);
        chk("n3_rst_empty",   64'(bus3.empty),        64'h7);
        drive3(1'b0, 1'b0, 0, '0, 1'b0, 0);
        chk("n3_rst_hold_rv", 64'(bus3.rd_valid),     64'h0);

        // reset state
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);

        // fill ch2 to full, then drain in order
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 2, DW'(i), 1'b0, 0, '0);
        for (int i = 0; i < 8; i++)  step(1'b0, 1'b0, 0, '0, 1'b1, 2, '0);
        idle4(1);

        // steady one-in/one-out on ch0 across pointer wrap
        step(1'b0, 1'b1, 0, 20'h00100, 1'b0, 0, '0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0, DW'(20'h00200 + i), 1'b1, 0, '0);
        step(1'b0, 1'b0, 0, '0, 1'b1, 0, '0);

        // write to full ch1 with same-cycle read; read of empty ch3 with same-cycle write
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, DW'(20'h01000 + i), 1'b0, 0, '0);
        step(1'b0, 1'b1, 1, 20'h09999, 1'b1, 1, '0);
        idle4(1);
        step(1'b0, 1'b1, 3, 20'h03333, 1'b1, 3, '0);
        idle4(1);

        // flush ch0 with a concurrent write; ch1 content must survive
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 0, DW'(20'h0A000 + i), 1'b0, 0, '0);
            step(1'b0, 1'b1, 1, DW'(20'h0B000 + i), 1'b0, 0, '0);
        end
        step(1'b0, 1'b1, 0, 20'h0AFFF, 1'b0, 0, 4'b0001);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, '0, 1'b1, 1, '0);
        idle4(1);

        // random traffic: a fill-biased phase then a drain-biased phase
        for (int i = 0; i < 1200; i++) begin
            logic [NCH-1:0] fl;
            bit             rs;
            wp = (i < 600) ? 70 : 35;
            rp = (i < 600) ? 35 : 70;
            fl = ($urandom_range(0, 29) == 0) ? NCH'(1 << $urandom_range(0, NCH-1)) : '0;
            rs = ($urandom_range(0, 249) == 0);
            step(rs, ($urandom_range(0, 99) < wp), int'($urandom_range(0, NCH-1)),
                 DW'($urandom), ($urandom_range(0, 99) < rp), int'($urandom_range(0, NCH-1)), fl);
        end

        // reset arriving together with a legal read
        step(1'b0, 1'b1, 0, 20'h0C0DE, 1'b0, 0, '0);
        step(1'b1, 1'b0, 0, '0, 1'b1, 0, '0);
        idle4(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
